// File: rtl/branch_trace_buffer.sv
`default_nettype none
// branch_trace_buffer: timestamps resolved-branch events into a show-ahead FIFO
// drained over valid/ready, with drop accounting and freeze/clear. Rev 1.0
module branch_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int TS_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              branch_event_valid,
  input  logic [31:0]       branch_event_pc,
  input  logic              branch_event_taken,
  input  logic              slot_event_is_nop,
  input  logic              slot_event_is_auto,
  input  logic              freeze,
  input  logic              clear,
  output logic              trace_valid,
  input  logic              trace_ready,
  output logic [31:0]       trace_pc,
  output logic              trace_taken,
  output logic              trace_slot_nop,
  output logic              trace_slot_auto,
  output logic [TS_W-1:0]   trace_cycle,
  output logic [ADDR_W:0]   fill_level,
  output logic [15:0]       drop_count,
  output logic              overflow
);

  localparam int              ENTRY_W    = 32 + 3 + TS_W;
  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W+1)'(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [ADDR_W:0]    count;
  logic [TS_W-1:0]    ts;
  logic [15:0]        drops;
  logic               ovf;

  logic capture;
  logic full;
  logic push;
  logic pop;
  logic drop;

  // clear outranks every other action, so it gates capture and pop alike
  assign capture = branch_event_valid && !freeze && !clear;
  assign full    = (count == FULL_LEVEL);
  assign pop     = (count != '0) && trace_ready && !clear;
  assign push    = capture && (!full || pop);
  assign drop    = capture && full && !pop;

  always_ff @(posedge clk) begin
    if (reset) ts <= '0;
    else       ts <= ts + TS_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {branch_event_pc, branch_event_taken,
                      slot_event_is_nop, slot_event_is_auto, ts};
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      drops  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
      if (drop) begin
        ovf <= 1'b1;
        if (drops != 16'hFFFF) drops <= drops + 16'd1;
      end
    end
  end

  assign trace_valid = (count != '0);
  assign {trace_pc, trace_taken, trace_slot_nop, trace_slot_auto, trace_cycle} = mem[rd_ptr];
  assign fill_level  = count;
  assign drop_count  = drops;
  assign overflow    = ovf;

endmodule
`default_nettype wire

// File: tb/tb_branch_trace_buffer.sv
`default_nettype none
// tb_branch_trace_buffer: directed self-checking bench for branch_trace_buffer.
// Rev 1.0
module tb_branch_trace_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        branch_event_valid;
  logic [31:0] branch_event_pc;
  logic        branch_event_taken;
  logic        slot_event_is_nop;
  logic        slot_event_is_auto;
  logic        freeze;
  logic        clear;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic        trace_taken;
  logic        trace_slot_nop;
  logic        trace_slot_auto;
  logic [15:0] trace_cycle;
  logic [4:0]  fill_level;
  logic [15:0] drop_count;
  logic        overflow;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [15:0] exp_ts = '0;
  logic [15:0] cap;

  branch_trace_buffer #(.DEPTH(16), .ADDR_W(4), .TS_W(16)) dut (
    .clk                (clk),
    .reset              (reset),
    .branch_event_valid (branch_event_valid),
    .branch_event_pc    (branch_event_pc),
    .branch_event_taken (branch_event_taken),
    .slot_event_is_nop  (slot_event_is_nop),
    .slot_event_is_auto (slot_event_is_auto),
    .freeze             (freeze),
    .clear              (clear),
    .trace_valid        (trace_valid),
    .trace_ready        (trace_ready),
    .trace_pc           (trace_pc),
    .trace_taken        (trace_taken),
    .trace_slot_nop     (trace_slot_nop),
    .trace_slot_auto    (trace_slot_auto),
    .trace_cycle        (trace_cycle),
    .fill_level         (fill_level),
    .drop_count         (drop_count),
    .overflow           (overflow)
  );

  always #5 clk = ~clk;

  // Advance one clock; the local timestamp model follows the DUT counter rule.
  task automatic tick();
    @(posedge clk);
    if (reset) exp_ts = '0;
    else       exp_ts = exp_ts + 16'd1;
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle event; returns the timestamp it should be stamped with.
  task automatic ev(input logic [31:0] p, output logic [15:0] ts_at);
    branch_event_valid = 1'b1;
    branch_event_pc    = p;
    ts_at              = exp_ts;
    tick();
    branch_event_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; branch_event_valid = 0; branch_event_pc = '0; branch_event_taken = 0;
    slot_event_is_nop = 0; slot_event_is_auto = 0; freeze = 0; clear = 0; trace_ready = 0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_valid", 64'(trace_valid), 64'd0);
    chk("rst_fill", 64'(fill_level), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);

    // single event
    branch_event_taken = 1; slot_event_is_auto = 1;
    tick(); tick();
    ev(32'h40, cap);
    branch_event_taken = 0; slot_event_is_auto = 0;
    chk("s_valid", 64'(trace_valid), 64'd1);
    chk("s_pc", 64'(trace_pc), 64'h40);
    chk("s_taken", 64'(trace_taken), 64'd1);
    chk("s_auto", 64'(trace_slot_auto), 64'd1);
    chk("s_nop", 64'(trace_slot_nop), 64'd0);
    chk("s_cycle", 64'(trace_cycle), 64'(cap));
    chk("s_fill", 64'(fill_level), 64'd1);
    trace_ready = 1; tick(); trace_ready = 0;
    chk("s_pop_fill", 64'(fill_level), 64'd0);
    chk("s_pop_valid", 64'(trace_valid), 64'd0);
    trace_ready = 1; tick(); trace_ready = 0;
    chk("s_empty_ready", 64'(fill_level), 64'd0);

    // fill and overflow
    for (int i = 0; i < 18; i++) ev(32'h100 + 32'(4*i), cap);
    chk("f_fill", 64'(fill_level), 64'd16);
    chk("f_drop", 64'(drop_count), 64'd2);
    chk("f_ovf", 64'(overflow), 64'd1);
    chk("f_head", 64'(trace_pc), 64'h100);

    // full with simultaneous push/pop
    slot_event_is_nop = 1; trace_ready = 1;
    ev(32'h200, cap);
    slot_event_is_nop = 0; trace_ready = 0;
    chk("pp_fill", 64'(fill_level), 64'd16);
    chk("pp_drop", 64'(drop_count), 64'd2);
    for (int i = 0; i < 16; i++) begin
      chk("drain_valid", 64'(trace_valid), 64'd1);
      chk("drain_pc", 64'(trace_pc), (i < 15) ? 64'(32'h104 + 32'(4*i)) : 64'h200);
      trace_ready = 1; tick(); trace_ready = 0;
    end
    chk("pp_last_nop", 64'(fill_level), 64'd0);
    chk("drain_ovf_kept", 64'(overflow), 64'd1);

    // freeze
    clear = 1; tick(); clear = 0;
    chk("clr_drop", 64'(drop_count), 64'd0);
    chk("clr_ovf", 64'(overflow), 64'd0);
    freeze = 1;
    for (int i = 0; i < 5; i++) ev(32'h280 + 32'(4*i), cap);
    freeze = 0;
    chk("fz_fill", 64'(fill_level), 64'd0);
    chk("fz_drop", 64'(drop_count), 64'd0);
    chk("fz_ovf", 64'(overflow), 64'd0);
    ev(32'h300, cap);
    chk("fz_after_fill", 64'(fill_level), 64'd1);

    // clear priority: reach 3 entries with overflow set
    for (int i = 0; i < 16; i++) ev(32'h310 + 32'(4*i), cap);
    chk("cp_full", 64'(fill_level), 64'd16);
    trace_ready = 1;
    for (int i = 0; i < 13; i++) tick();
    trace_ready = 0;
    chk("cp_fill3", 64'(fill_level), 64'd3);
    chk("cp_ovf", 64'(overflow), 64'd1);
    chk("cp_drop", 64'(drop_count), 64'd1);
    clear = 1; trace_ready = 1;
    ev(32'h400, cap);
    clear = 0; trace_ready = 0;
    chk("cp_fill", 64'(fill_level), 64'd0);
    chk("cp_valid", 64'(trace_valid), 64'd0);
    chk("cp_drop0", 64'(drop_count), 64'd0);
    chk("cp_ovf0", 64'(overflow), 64'd0);
    ev(32'h500, cap);
    chk("cp_ts_cont", 64'(trace_cycle), 64'(cap));
    chk("cp_pc", 64'(trace_pc), 64'h500);
    trace_ready = 1; tick(); trace_ready = 0;

    // streaming across pointer wrap
    trace_ready = 1;
    for (int i = 0; i < 40; i++) begin
      ev(32'h1000 + 32'(4*i), cap);
      chk("st_pc", 64'(trace_pc), 64'(32'h1000 + 32'(4*i)));
      chk("st_fill", 64'(fill_level), 64'd1);
    end
    tick();
    trace_ready = 0;
    chk("st_empty", 64'(fill_level), 64'd0);
    chk("st_drop", 64'(drop_count), 64'd0);

    // timestamp wrap
    while (exp_ts != 16'hFFFF) tick();
    ev(32'h600, cap);
    ev(32'h604, cap);
    chk("tw_pc0", 64'(trace_pc), 64'h600);
    chk("tw_cyc0", 64'(trace_cycle), 64'hFFFF);
    trace_ready = 1; tick(); trace_ready = 0;
    chk("tw_pc1", 64'(trace_pc), 64'h604);
    chk("tw_cyc1", 64'(trace_cycle), 64'h0);

    // reset mid-operation overrides freeze/clear/handshake
    ev(32'h700, cap);
    reset = 1; freeze = 1; trace_ready = 1;
    tick();
    reset = 0; freeze = 0; trace_ready = 0;
    chk("mr_fill", 64'(fill_level), 64'd0);
    chk("mr_valid", 64'(trace_valid), 64'd0);
    ev(32'h800, cap);
    chk("mr_cycle", 64'(trace_cycle), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_trace_buffer.md
Name: branch_trace_buffer

Overview:
- Consumer for the pipeline's branch/slot event stream.
- Timestamps each branch event and stores it in a show-ahead FIFO.
- A debug reader or testbench drains entries over a valid/ready handshake.
- Sits beside the core wrapper and adds overflow accounting plus freeze/clear controls for post-run trace inspection.

Parameters:
- DEPTH, 16, number of trace entries; power of two, at least 2.
- ADDR_W, 4, log2(DEPTH).
- TS_W, 16, timestamp counter width.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- branch_event_valid  input  1  branch resolved this cycle
- branch_event_pc  input  32  PC of the resolved branch
- branch_event_taken  input  1  branch taken
- slot_event_is_nop  input  1  delay slot filled with NOP
- slot_event_is_auto  input  1  delay slot auto-filled
- freeze  input  1  suppress capture while high
- clear  input  1  synchronous flush of FIFO and drop counter
- trace_valid  output  1  head entry available
- trace_ready  input  1  reader accepts head entry
- trace_pc  output  32  head entry PC
- trace_taken  output  1  head entry taken flag
- trace_slot_nop  output  1  head entry NOP-slot flag
- trace_slot_auto  output  1  head entry auto-slot flag
- trace_cycle  output  TS_W  head entry timestamp
- fill_level  output  ADDR_W+1  entries stored
- drop_count  output  16  events lost to a full FIFO (saturating)
- overflow  output  1  sticky: at least one drop since reset/clear

Behaviour:
- Reset (synchronous, active-high): wr_ptr=rd_ptr=0, fill_level=0, trace_valid=0, drop_count=0, overflow=0, timestamp=0.
- Head data outputs are don't-care while trace_valid=0. Benches must not check them then.
- Timestamp: free-running TS_W-bit counter. Increments every non-reset cycle and wraps from all-ones to 0. clear does not reset it.
- Entry format: {pc, taken, is_nop, is_auto, timestamp}. The timestamp is the counter value in the cycle the event is sampled.
- Push condition: branch_event_valid=1, freeze=0, clear=0, and (fill_level<DEPTH or a pop occurs the same cycle).
  - The entry is written at wr_ptr.
  - wr_ptr advances modulo DEPTH.
- Drop condition: branch_event_valid=1, freeze=0, clear=0, FIFO full, no same-cycle pop.
  - The event is discarded.
  - drop_count increments, saturating at 16'hFFFF.
  - overflow is set to 1.
- Frozen events (freeze=1) are discarded silently. drop_count and overflow do not change.
- Read handshake:
  - trace_valid = (fill_level != 0).
  - Data comes combinationally from rd_ptr (show-ahead).
  - Pop happens when trace_valid && trace_ready && !clear; rd_ptr then advances modulo DEPTH.
  - trace_ready while empty has no effect.
- Push-to-visible latency: 1 cycle. An event pushed in cycle N into an empty FIFO gives trace_valid=1 in cycle N+1.
- Simultaneous push and pop: both take effect and fill_level is unchanged. This holds when full and when holding one entry. A one-entry FIFO shows the new entry next cycle.
- fill_level: +1 on push-only, -1 on pop-only, unchanged otherwise. Range 0..DEPTH.
- clear has priority over push, pop and drop. Next cycle: pointers=0, fill_level=0, trace_valid=0, drop_count=0, overflow=0.
- Reset asserted mid-operation behaves as reset regardless of freeze, clear or handshake state. In-flight entries are lost.
- Pointer wrap: pointers carry no extra wrap bit; full/empty is derived from fill_level only.

Test Plan:
- Single event: reset, then drive valid for one cycle with pc=0x00000040, taken=1, auto=1. Required: next cycle trace_valid=1, trace_pc=0x40, trace_taken=1, trace_slot_auto=1, trace_cycle = counter value at capture, fill_level=1. Pop with ready=1 gives fill_level=0.
- Fill and overflow: with ready=0, push 18 events with pc=0x100+4*i. Required: fill_level=16, drop_count=2, overflow=1. Draining returns pc 0x100..0x13C in order.
- Full with simultaneous push/pop: from full, drive valid and ready together for one cycle. Required: fill_level stays 16, drop_count unchanged. The new entry appears last on drain.
- Freeze: freeze=1 with 5 events. Required: fill_level=0, drop_count=0, overflow=0. Deassert freeze and push 1 event: fill_level=1.
- Clear priority: with 3 entries and overflow=1, assert clear together with valid and ready. Required next cycle: fill_level=0, trace_valid=0, drop_count=0, overflow=0. The timestamp keeps counting.
- Pointer and timestamp wrap: stream 40 events with ready=1 continuously. Required: all 40 pc values emerged in order, no drops. Run past 65535 cycles: trace_cycle wraps to 0 correctly.
